// File: rtl/pixel_block_collector.sv
// Ping-pong serial-to-parallel block assembler: packs NUM_INTEGERS pixel samples
// into one flat bus. One bank fills while the other is held for the downstream converter.
module pixel_block_collector #(
  parameter int INPUT_BITS   = 8,
  parameter int NUM_INTEGERS = 64,
  parameter int IDX_BITS     = $clog2(NUM_INTEGERS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [INPUT_BITS-1:0]            pix_in,
  input  logic                             pix_valid,
  input  logic                             pix_last,
  output logic                             pix_ready,
  output logic [NUM_INTEGERS*INPUT_BITS-1:0] integers,
  output logic                             blk_valid,
  input  logic                             blk_ready,
  output logic [IDX_BITS-1:0]              fill_idx,
  output logic                             err_align,
  input  logic                             err_clr
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_INTEGERS - 1);

  typedef logic [NUM_INTEGERS-1:0][INPUT_BITS-1:0] block_t;

  block_t              bank_data [2];
  logic [1:0]          full_q, full_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IDX_BITS-1:0] fill_idx_q, fill_idx_d;
  logic                err_q, err_d;

  logic accept, release_blk, at_last, early_last, missing_last, complete;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    fill_idx_d  = fill_idx_q;
    err_d       = err_q;

    accept       = pix_valid && !full_q[wr_bank_q];
    release_blk  = full_q[rd_bank_q] && blk_ready;
    at_last      = (fill_idx_q == LAST_IDX);
    early_last   = accept && pix_last && !at_last;
    missing_last = accept && !pix_last && at_last;
    complete     = accept && at_last;

    // Completing and releasing always target different banks: a filling bank is
    // never full, a releasing bank always is.
    if (complete) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (release_blk) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      if (at_last || pix_last) fill_idx_d = '0;
      else                     fill_idx_d = fill_idx_q + IDX_BITS'(1);
    end

    // A new framing error takes priority over a simultaneous clear.
    if (early_last || missing_last) err_d = 1'b1;
    else if (err_clr)               err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      fill_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      fill_idx_q <= fill_idx_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the bank storage is reset on purpose so the output bus reads zero out
  // of reset and no data from before a reset can ever be presented downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_data <= '{default: '0};
    end else if (accept && !early_last) begin
      bank_data[wr_bank_q][fill_idx_q] <= pix_in;
    end
  end

  // All outputs come straight from state registers; no input reaches them combinationally.
  assign pix_ready = !full_q[wr_bank_q];
  assign blk_valid = full_q[rd_bank_q];
  assign integers  = bank_data[rd_bank_q];
  assign fill_idx  = fill_idx_q;
  assign err_align = err_q;

endmodule

// File: tb/tb_pixel_block_collector.sv
// Self-checking bench for pixel_block_collector: directed scenarios plus random
// traffic, compared each cycle against a queue-based block model.
module tb_pixel_block_collector;

  localparam int W  = 8;
  localparam int N  = 64;
  localparam int IB = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   pix_in = '0;
  logic           pix_valid = 1'b0;
  logic           pix_last = 1'b0;
  logic           blk_ready = 1'b0;
  logic           err_clr = 1'b0;
  logic           pix_ready;
  logic           blk_valid;
  logic           err_align;
  logic [N*W-1:0] integers;
  logic [IB-1:0]  fill_idx;

  pixel_block_collector #(.INPUT_BITS(W), .NUM_INTEGERS(N)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_ready(pix_ready), .integers(integers),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .fill_idx(fill_idx),
    .err_align(err_align), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: completed blocks waiting downstream, plus the partial block.
  logic [N*W-1:0] pend [$];
  logic [N*W-1:0] cur;
  int             cur_cnt;
  bit             m_err;
  int             n_cmp = 0;
  int             n_mis = 0;

  task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("pix_ready", N*W'(pix_ready), N*W'(pend.size() < 2));
    check("blk_valid", N*W'(blk_valid), N*W'(pend.size() > 0));
    check("fill_idx",  N*W'(fill_idx),  N*W'(cur_cnt));
    check("err_align", N*W'(err_align), N*W'(m_err));
    if (pend.size() > 0) check("integers", integers, pend[0]);
  endtask

  task automatic model_reset();
    pend.delete();
    cur     = '0;
    cur_cnt = 0;
    m_err   = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs at the falling edge, advance model at the rising edge.
  task automatic cycle(input bit pv, input logic [W-1:0] pi, input bit pl, input bit br,
                       input bit ec, output bit acc);
    bit rel, new_err;
    pix_valid = pv; pix_in = pi; pix_last = pl; blk_ready = br; err_clr = ec;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    acc     = pv && (pend.size() < 2);
    rel     = (pend.size() > 0) && br;
    new_err = 1'b0;
    if (rel) void'(pend.pop_front());
    if (acc) begin
      if (pl && cur_cnt < N - 1) begin
        cur_cnt = 0;
        new_err = 1'b1;
      end else begin
        cur[cur_cnt*W +: W] = pi;
        cur_cnt++;
        if (cur_cnt == N) begin
          pend.push_back(cur);
          cur_cnt = 0;
          if (!pl) new_err = 1'b1;
        end
      end
    end
    if (new_err)  m_err = 1'b1;
    else if (ec)  m_err = 1'b0;
    #1;
  endtask

  task automatic idle(input int n, input bit br);
    bit acc;
    repeat (n) cycle(1'b0, '0, 1'b0, br, 1'b0, acc);
  endtask

  task automatic send(input logic [W-1:0] v, input bit l, input bit br);
    bit acc;
    int guard = 0;
    do begin
      cycle(1'b1, v, l, br, 1'b0, acc);
      guard++;
    end while (!acc && guard < 300);
    check("send_timeout", N*W'(acc), N*W'(1));
  endtask

  task automatic send_block(input int base, input bit with_last, input bit br);
    for (int i = 0; i < N; i++) send(W'(base + i), with_last && (i == N - 1), br);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pix_valid = 1'b0; pix_last = 1'b0; blk_ready = 1'b0; err_clr = 1'b0;
    #1;
    check("rst_pix_ready", N*W'(pix_ready), N*W'(1));
    check("rst_blk_valid", N*W'(blk_valid), '0);
    check("rst_fill_idx",  N*W'(fill_idx),  '0);
    check("rst_err_align", N*W'(err_align), '0);
    check("rst_integers",  integers,        '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit acc;
    logic [N*W-1:0] exp_blk;
    #2;
    do_reset();

    // Single block 0..63 with pix_last on the final sample.
    send_block(0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) exp_blk[i*W +: W] = W'(i);
    check("blk0_valid", N*W'(blk_valid), N*W'(1));
    check("blk0_data", integers, exp_blk);
    check("blk0_err", N*W'(err_align), '0);
    idle(3, 1'b1);

    // Three back-to-back blocks; pix_ready must stay high throughout.
    for (int b = 0; b < 3; b++) send_block(b * N, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Backpressure: two blocks fill both banks, the 129th sample waits.
    send_block(8'h40, 1'b1, 1'b0);
    send_block(8'h80, 1'b1, 1'b0);
    check("bp_ready_low", N*W'(pix_ready), '0);
    repeat (3) cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, acc);
    check("bp_not_taken", N*W'(fill_idx), '0);
    idle(4, 1'b1);
    check("bp_ready_back", N*W'(pix_ready), N*W'(1));
    for (int i = 0; i < N; i++) send(W'(8'hAA + i), i == N - 1, 1'b1);
    idle(3, 1'b1);

    // Early last on the 10th sample, then a clean block, then clear.
    for (int i = 0; i < 10; i++) send(W'(i + 8'hF0), i == 9, 1'b1);
    check("early_err", N*W'(err_align), N*W'(1));
    check("early_idx", N*W'(fill_idx), '0);
    check("early_no_blk", N*W'(blk_valid), '0);
    send_block(8'h11, 1'b1, 1'b1);
    idle(2, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, acc);
    check("err_cleared", N*W'(err_align), '0);

    // Missing last: block still delivered, error raised.
    send_block(8'h22, 1'b0, 1'b1);
    check("missing_err", N*W'(err_align), N*W'(1));
    idle(3, 1'b1);

    // Reset after 30 samples, then a fresh block must carry no stale data.
    for (int i = 0; i < 30; i++) send(W'(8'h99), 1'b0, 1'b1);
    do_reset();
    send_block(8'h05, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Random traffic with occasional framing errors, stalls and clears.
    for (int c = 0; c < 1500; c++) begin
      bit pv, pl, br, ec;
      pv = $urandom_range(0, 9) < 7;
      pl = (cur_cnt == N - 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 99) == 0);
      br = $urandom_range(0, 9) < 6;
      ec = $urandom_range(0, 19) == 0;
      cycle(pv, W'($urandom), pl, br, ec, acc);
    end
    idle(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pixel_block_collector.md
Name: pixel_block_collector

Overview:
Serial-to-parallel block assembler that sits directly upstream of the parallel integer-to-fixed converter. It accepts raw pixel samples one per clock over a valid/ready stream and packs each run of NUM_INTEGERS samples (an 8x8 block by default) into one flat bus. It double-buffers (ping-pong) so that one bank fills while the other is held for the converter. The output bus layout matches the converter's `integers` input exactly.

Parameters:
- INPUT_BITS, 8, width of one pixel sample.
- NUM_INTEGERS, 64, samples per block; must be ≥2.
- IDX_BITS, $clog2(NUM_INTEGERS), width of the sample index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- pix_in  in  INPUT_BITS  pixel sample.
- pix_valid  in  1  pix_in is valid.
- pix_last  in  1  marks the final sample of a block; qualified by pix_valid.
- pix_ready  out  1  block can accept a sample this cycle.
- integers  out  NUM_INTEGERS*INPUT_BITS  packed block; sample i at [i*INPUT_BITS +: INPUT_BITS].
- blk_valid  out  1  integers holds a complete block.
- blk_ready  in  1  downstream consumes the block.
- fill_idx  out  IDX_BITS  write index within the current filling bank.
- err_align  out  1  sticky framing error.
- err_clr  in  1  synchronous clear of err_align.

Behaviour:
- Reset (async assert, sync release) clears the following:
  - both banks' data to 0 and both bank-full flags to 0;
  - wr_bank=0, rd_bank=0, fill_idx=0;
  - blk_valid=0, integers=0, err_align=0, pix_ready=1.
  - A reset mid-fill or mid-hold discards all buffered data.
- Transfer-in occurs when pix_valid && pix_ready. The sample is written to bank[wr_bank] at slot fill_idx, in raster order: first accepted = slot 0.
- pix_ready = !full[wr_bank]. It is purely register-driven, with no combinational path from blk_ready or pix_valid.
- Normal completion: transfer-in with fill_idx==NUM_INTEGERS-1 does the following:
  - sets full[wr_bank];
  - fill_idx←0;
  - toggles wr_bank.
- Framing:
  - pix_last=1 with fill_idx<NUM_INTEGERS-1 (early last): the partial block is discarded. fill_idx←0, same bank stays filling, full not set, err_align←1.
  - pix_last=0 at fill_idx==NUM_INTEGERS-1 (missing last): the block completes normally and err_align←1.
  - err_align stays set until err_clr is asserted. If err_clr is asserted in the same cycle as a new error, set wins.
- Output side:
  - blk_valid = full[rd_bank] (registered).
  - integers = data of bank[rd_bank]. It is stable whenever blk_valid && !blk_ready.
  - Transfer-out on blk_valid && blk_ready: clear full[rd_bank] and toggle rd_bank.
- Latency: when the final sample is accepted at edge t, blk_valid=1 after edge t. A freed bank raises pix_ready on the following cycle.
- Simultaneous completion of one bank and release of the other in the same cycle are both honoured. No sample or block is lost or duplicated.
- Throughput: with blk_ready held high, sustained 1 sample/cycle with zero pix_ready deassertion.
- Backpressure: if both banks are full, pix_ready=0. Samples offered while pix_ready=0 are ignored and the source must hold them.
- Blocks leave in arrival order, and rd_bank always trails wr_bank.
- Latched bank data are never modified while full is set.

Test Plan:
- Reset then 64 samples 0..63, pix_last on the 64th, blk_ready=1:
  - blk_valid pulses 1 cycle after the last sample;
  - slice i of integers == i;
  - err_align=0.
- Continuous 3 blocks (values block*64+i), blk_ready=1:
  - pix_ready never drops;
  - three blk_valid pulses 64 cycles apart with correct contents.
- blk_ready=0 while 2 blocks are sent:
  - after 128 samples pix_ready=0 and the 129th sample is not accepted;
  - raising blk_ready yields block0, then block1, then pix_ready=1.
- pix_last at sample 10:
  - err_align=1, fill_idx returns to 0, no blk_valid;
  - the next 64 samples form a correct block;
  - err_clr then clears err_align.
- 64 samples without pix_last: the block is delivered and err_align=1.
- rst_n pulsed low after 30 samples: all outputs return to reset values immediately and no stale data appears in later blocks.
